// File: rtl/s2cif_mon_pkg.sv
// s2cif_mon_pkg
//   Shared types for the s2cif word-packing output monitor.
//   mon_state_e : monitor run state (RUN, CLOSED)
//   mon_entry_t : one buffered word with its valid bit count and timestamp
package s2cif_mon_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    CLOSED = 1'b1
  } mon_state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [5:0]  count;
    logic [31:0] tstamp;
  } mon_entry_t;

endpackage

// File: rtl/s2cif_if.sv
// s2cif_if
//   Signal-level form of the s2cif call channel between the monitor and the
//   scenario side.
//   chan_id, func_no : channel id / function index used for setup and pushes
//   setup_ret        : scenario result of func_setup; non-zero keeps the
//                      monitor halted
//   call             : a data_push_call is issued this cycle
//   data0..data2     : push arguments (word, bit count, timestamp)
//   ret              : scenario return value for the call of this cycle,
//                      consumed on the next posedge
interface s2cif_if;
  logic [31:0]        chan_id;
  logic [31:0]        func_no;
  logic signed [31:0] setup_ret;
  logic               call;
  logic [31:0]        data0;
  logic [31:0]        data1;
  logic [31:0]        data2;
  logic signed [31:0] ret;

  modport mon (
    output chan_id, func_no, call, data0, data1, data2,
    input  setup_ret, ret
  );
endinterface

// File: rtl/s2cif_mon_fifo.sv
// s2cif_mon_fifo
//   Synchronous FIFO of mon_entry_t, DEPTH a power of 2 (>= 2).
//   A push while full is accepted only when a pop happens on the same edge.
//   Macro S2CIF_MON_TSTAMP_EN: when defined, the timestamp field is stored;
//   otherwise it is not stored and reads back as zero.
//   Ports: clk, rst (async, active-high), push/din, pop/dout,
//          full, empty, count (entries held)
module s2cif_mon_fifo
  import s2cif_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  mon_entry_t                 din,
  input  logic                       pop,
  output mon_entry_t                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   word_mem [DEPTH];
  logic [5:0]    cnt_mem  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage arrays carry no reset; only pointers and count define
  // validity, and leaving the data unreset lets it map onto plain RAM/regs.
  always_ff @(posedge clk) begin
    if (do_push) begin
      word_mem[wr_ptr] <= din.word;
      cnt_mem[wr_ptr]  <= din.count;
    end
  end

`ifdef S2CIF_MON_TSTAMP_EN
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (do_push) ts_mem[wr_ptr] <= din.tstamp;
  end

  assign dout = {word_mem[rd_ptr], cnt_mem[rd_ptr], ts_mem[rd_ptr]};
`else
  logic unused_ts;
  assign unused_ts = ^din.tstamp;
  assign dout      = {word_mem[rd_ptr], cnt_mem[rd_ptr], 32'd0};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mon_s2cif_pack.sv
// mon_s2cif_pack
//   Output monitor downstream of the s2cif bit driver. Packs the DUT serial
//   bit LSB-first into WORD_BITS-wide words, buffers them in a DEPTH-entry
//   FIFO and drains one word per cycle to the scenario via s2cif pushes
//   (data0=word, data1=bit count, data2=timestamp). ret==0 pops, ret>0
//   retries the head next cycle, ret<0 closes the monitor until rst.
//   A non-zero setup_ret keeps the monitor halted (no capture, no pushes).
//   Macro S2CIF_MON_TSTAMP_EN: adds a free-running cycle counter latched
//   into each entry at enqueue; undefined, data2 is 0.
//   Ports: clk, rst (async, active-high), s2cif (mon modport), dout, cap_en,
//          flush (1-cycle pulse), fifo_full, ovf (sticky drop), closed,
//          word_cnt (accepted words, wraps)
module mon_s2cif_pack
  import s2cif_mon_pkg::*;
#(
  parameter int id        = 0,
  parameter int FUNC_NO   = 2,
  parameter int WORD_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  s2cif_if.mon        s2cif,
  input  logic        dout,
  input  logic        cap_en,
  input  logic        flush,
  output logic        fifo_full,
  output logic        ovf,
  output logic        closed,
  output logic [31:0] word_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [5:0] LAST_BIT = 6'(WORD_BITS - 1);

  mon_state_e  state_q, state_d;
  logic [31:0] acc, acc_new;
  logic [5:0]  bit_cnt, eff_cnt;
  logic        run, cap, complete, flush_enq, enq, enq_ok;
  logic        call, pop, ret_end;
  mon_entry_t  entry, head;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;

  assign run      = (state_q == RUN) && (s2cif.setup_ret == 0);
  assign cap      = run && cap_en;
  assign eff_cnt  = bit_cnt + {5'd0, cap};
  assign complete = cap && (bit_cnt == LAST_BIT);
  // A flush on the completing cycle is absorbed by the full word.
  assign flush_enq = run && flush && !complete && (eff_cnt != 6'd0);
  assign enq       = complete || flush_enq;

  // Bits above bit_cnt are always zero, so writing one bit yields the
  // zero-extended partial word directly.
  // NOTE: every always_comb output gets a default first so no latch forms.
  always_comb begin
    acc_new = acc;
    if (cap) acc_new[bit_cnt[4:0]] = dout;
  end

  assign call    = run && !fifo_empty;
  assign pop     = call && (s2cif.ret == 0);
  assign ret_end = call && (s2cif.ret < 0);
  assign enq_ok  = (fifo_count != CW'(DEPTH)) || pop;

`ifdef S2CIF_MON_TSTAMP_EN
  logic [31:0] cyc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end
  assign entry.tstamp = cyc;
`else
  assign entry.tstamp = 32'd0;
`endif
  assign entry.word  = acc_new;
  assign entry.count = complete ? 6'(WORD_BITS) : eff_cnt;

  s2cif_mon_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .din   (entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && ret_end) state_d = CLOSED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      bit_cnt  <= '0;
      ovf      <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (enq) begin
        acc     <= '0;
        bit_cnt <= '0;
      end else if (cap) begin
        acc     <= acc_new;
        bit_cnt <= eff_cnt;
      end
      if (enq && !enq_ok) ovf <= 1'b1;
      if (pop) word_cnt <= word_cnt + 32'd1;
    end
  end

  assign closed        = (state_q == CLOSED);
  assign s2cif.chan_id = 32'(id);
  assign s2cif.func_no = 32'(FUNC_NO);
  assign s2cif.call    = call;
  assign s2cif.data0   = head.word;
  assign s2cif.data1   = {26'd0, head.count};
  assign s2cif.data2   = head.tstamp;

endmodule

// File: tb/tb_mon_s2cif_pack.sv
// tb_mon_s2cif_pack
//   Directed bench for mon_s2cif_pack (WORD_BITS=8, DEPTH=4). The scenario
//   side answers each push with ret=1 while calls_total < busy_until, else
//   with ret_after; every push is logged on the posedge it is consumed.
module tb_mon_s2cif_pack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dout = 1'b0;
  logic cap_en = 1'b0;
  logic flush = 1'b0;
  logic fifo_full, ovf, closed;
  logic [31:0] word_cnt;

  logic [31:0]        calls_total = 32'd0;
  logic [31:0]        busy_until  = 32'd0;
  logic signed [31:0] ret_after   = 32'sd0;
  logic [31:0]        last_d0 = 32'd0;
  logic [31:0]        last_d1 = 32'd0;
  logic [31:0]        last_d2 = 32'd0;

  int tests_run = 0;
  int tests_failed = 0;

  s2cif_if s2cif ();

  assign s2cif.setup_ret = 32'sd0;
  assign s2cif.ret       = (calls_total < busy_until) ? 32'sd1 : ret_after;

  mon_s2cif_pack #(.id(0), .FUNC_NO(2), .WORD_BITS(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s2cif     (s2cif),
    .dout      (dout),
    .cap_en    (cap_en),
    .flush     (flush),
    .fifo_full (fifo_full),
    .ovf       (ovf),
    .closed    (closed),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  // Log updates land after the DUT has consumed ret for this edge.
  always @(posedge clk) begin
    if (s2cif.call) begin
      calls_total <= calls_total + 32'd1;
      last_d0     <= s2cif.data0;
      last_d1     <= s2cif.data1;
      last_d2     <= s2cif.data2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_en = 1'b1;
      dout   = b[i];
    end
    @(negedge clk);
    cap_en = 1'b0;
    dout   = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] c0, w0;

  initial begin
    idle(2);
    check("reset_closed", {31'd0, closed}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_word_cnt", word_cnt, 32'd0);
    check("reset_call", {31'd0, s2cif.call}, 32'd0);
    rst = 1'b0;
    idle(1);
    check("func_no", s2cif.func_no, 32'd2);

    // 1: one full byte, LSB first 1,0,1,1,0,0,0,1 -> 0x8D
    c0 = calls_total;
    send_bits(32'h8D, 8);
    check("t1_not_before_next_edge", calls_total, c0);
    check("t1_call_pending", {31'd0, s2cif.call}, 32'd1);
    idle(3);
    check("t1_calls", calls_total - c0, 32'd1);
    check("t1_word", last_d0, 32'h8D);
    check("t1_count", last_d1, 32'd8);
`ifndef S2CIF_MON_TSTAMP_EN
    check("t1_data2", last_d2, 32'd0);
`endif
    check("t1_word_cnt", word_cnt, 32'd1);

    // 2: partial word via flush, then empty flush
    c0 = calls_total;
    send_bits(32'h7, 3);
    pulse_flush();
    idle(3);
    check("t2_calls", calls_total - c0, 32'd1);
    check("t2_word", last_d0, 32'h7);
    check("t2_count", last_d1, 32'd3);
    check("t2_word_cnt", word_cnt, 32'd2);
    pulse_flush();
    idle(3);
    check("t2_empty_flush", calls_total - c0, 32'd1);

    // 2b: flush on the same cycle as a capture counts that bit (1,0,1)
    c0 = calls_total;
    send_bits(32'h1, 2);
    cap_en = 1'b1; dout = 1'b1; flush = 1'b1;
    @(negedge clk);
    cap_en = 1'b0; dout = 1'b0; flush = 1'b0;
    idle(3);
    check("t2b_word", last_d0, 32'h5);
    check("t2b_count", last_d1, 32'd3);

    // 2c: flush on the completing bit adds nothing extra
    c0 = calls_total;
    send_bits(32'h7F, 7);
    cap_en = 1'b1; dout = 1'b1; flush = 1'b1;
    @(negedge clk);
    cap_en = 1'b0; dout = 1'b0; flush = 1'b0;
    idle(3);
    check("t2c_calls", calls_total - c0, 32'd1);
    check("t2c_word", last_d0, 32'hFF);
    check("t2c_count", last_d1, 32'd8);

    // 3: five busy returns then accept
    c0 = calls_total;
    w0 = word_cnt;
    busy_until = calls_total + 32'd5;
    send_bits(32'h3C, 8);
    idle(12);
    check("t3_calls", calls_total - c0, 32'd6);
    check("t3_word", last_d0, 32'h3C);
    check("t3_word_cnt", word_cnt - w0, 32'd1);

    // 4: scenario permanently busy, overflow on the 5th word
    w0 = word_cnt;
    busy_until = 32'hFFFF_FFFF;
    send_bits(32'h11, 8);
    send_bits(32'h22, 8);
    send_bits(32'h33, 8);
    send_bits(32'h44, 8);
    check("t4_full_at_4", {31'd0, fifo_full}, 32'd1);
    check("t4_no_ovf_at_4", {31'd0, ovf}, 32'd0);
    send_bits(32'h55, 8);
    check("t4_ovf_at_5", {31'd0, ovf}, 32'd1);
    send_bits(32'h66, 8);
    check("t4_full_at_6", {31'd0, fifo_full}, 32'd1);
    check("t4_head_retried", last_d0, 32'h11);
    check("t4_no_accept", word_cnt - w0, 32'd0);
    busy_until = 32'd0;
    idle(8);
    check("t4_drained", word_cnt - w0, 32'd4);
    check("t4_last_word", last_d0, 32'h44);
    check("t4_not_full", {31'd0, fifo_full}, 32'd0);
    check("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

    // 5: scenario ends the stream
    c0 = calls_total;
    w0 = word_cnt;
    ret_after = -32'sd1;
    send_bits(32'h77, 8);
    idle(3);
    check("t5_closed", {31'd0, closed}, 32'd1);
    check("t5_calls", calls_total - c0, 32'd1);
    check("t5_no_accept", word_cnt - w0, 32'd0);
    send_bits(32'h88, 8);
    idle(5);
    check("t5_no_more_calls", calls_total - c0, 32'd1);
    rst = 1'b1;
    ret_after = 32'sd0;
    #1;
    check("t5_rst_closed", {31'd0, closed}, 32'd0);
    check("t5_rst_word_cnt", word_cnt, 32'd0);
    check("t5_rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("t5_fifo_cleared", calls_total - c0, 32'd1);

    // 6: reset mid-word discards the partial word
    c0 = calls_total;
    send_bits(32'h15, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_flush();
    idle(3);
    check("t6_no_partial", calls_total - c0, 32'd0);
    send_bits(32'hA5, 8);
    idle(3);
    check("t6_calls", calls_total - c0, 32'd1);
    check("t6_word", last_d0, 32'hA5);
    check("t6_count", last_d1, 32'd8);
    check("t6_word_cnt", word_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
